// File: rtl/deserializer_flex.sv
// Serial-to-parallel converter: DATA_W-bit words, selectable bit order, flush with length.
// Word valid one cycle after completion; a completion while the held word is unaccepted is dropped and pulses overflow_o.
module deserializer_flex #(
  parameter int DATA_W    = 16,
  parameter bit MSB_FIRST = 1'b0,
  parameter int LEN_W     = $clog2(DATA_W + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              data_i,
  input  logic              data_val_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [LEN_W-1:0]  deser_len_o,
  output logic              deser_data_val_o,
  input  logic              deser_data_ready_i,
  output logic              overflow_o
);

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_ins;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  eff_cnt;
  logic [LEN_W-1:0]  bit_idx;
  logic              complete;
  logic              out_free;

  // acc_ins/eff_cnt already include a bit accepted this cycle, so a flush can absorb it.
  always_comb begin
    bit_idx = MSB_FIRST ? (LEN_W'(DATA_W - 1) - cnt) : cnt;
    eff_cnt = cnt + LEN_W'(data_val_i);
    acc_ins = acc;
    for (int i = 0; i < DATA_W; i++) begin
      if (data_val_i && (bit_idx == LEN_W'(i))) acc_ins[i] = data_i;
    end
    complete = (data_val_i && (eff_cnt == LEN_W'(DATA_W))) || (flush_i && (eff_cnt != '0));
    out_free = !deser_data_val_o || deser_data_ready_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc              <= '0;
      cnt              <= '0;
      deser_data_o     <= '0;
      deser_len_o      <= '0;
      deser_data_val_o <= 1'b0;
      overflow_o       <= 1'b0;
    end else begin
      overflow_o <= 1'b0;
      if (complete) begin
        acc <= '0;
        cnt <= '0;
        if (out_free) begin
          deser_data_o     <= acc_ins;
          deser_len_o      <= eff_cnt;
          deser_data_val_o <= 1'b1;
        end else begin
          overflow_o <= 1'b1;
        end
      end else begin
        acc <= acc_ins;
        cnt <= eff_cnt;
        if (deser_data_val_o && deser_data_ready_i) deser_data_val_o <= 1'b0;
      end
    end
  end

endmodule
